// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU packed-SIMD execution stage.
// Lane geometry, Q8.8 constants, FSM states and decoder op indices.
package mpu_pkg;

   localparam int LANES = 4;
   localparam int LW    = 16;
   localparam int DW    = LANES * LW;

   localparam logic [LW-1:0] Q_ONE = 16'h0100;
   localparam logic [LW-1:0] Q_MAX = 16'h7FFF;
   localparam logic [LW-1:0] Q_MIN = 16'h8000;

   // Bit positions of the decoder strobes in the packed op vector
   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_MUL  = 2;
   localparam int OP_CMP  = 3;
   localparam int OP_SHF  = 4;
   localparam int OP_SFMX = 5;
   localparam int OP_ROOT = 6;
   localparam int OP_EXP  = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      LOP_ADD,
      LOP_SUB,
      LOP_MUL,
      LOP_CMP,
      LOP_SHF
   } lane_op_t;

   function automatic logic [LW-1:0] smax(input logic [LW-1:0] x, input logic [LW-1:0] y);
      return ($signed(x) > $signed(y)) ? x : y;
   endfunction

endpackage

// File: rtl/mpu_q88_lane.sv
// Combinational single-lane Q8.8 unit: add/sub/mul with saturation,
// signed compare and logical-left / arithmetic-right shift.
module mpu_q88_lane
   import mpu_pkg::*;
(
   input  lane_op_t      op,
   input  logic [LW-1:0] a,
   input  logic [LW-1:0] b,
   output logic [LW-1:0] y,
   output logic          ovf
);

   logic [LW:0]     s;
   logic [2*LW-1:0] p;

   always_comb begin
      y   = '0;
      ovf = 1'b0;
      s   = '0;
      p   = '0;
      case (op)
         LOP_ADD, LOP_SUB: begin
            s = (op == LOP_ADD) ? ({a[LW-1], a} + {b[LW-1], b})
                                : ({a[LW-1], a} - {b[LW-1], b});
            if (s[LW] != s[LW-1]) begin
               ovf = 1'b1;
               y   = s[LW] ? Q_MIN : Q_MAX;
            end else begin
               y = s[LW-1:0];
            end
         end
         LOP_MUL: begin
            p = $signed({{LW{a[LW-1]}}, a}) * $signed({{LW{b[LW-1]}}, b});
            // Q8.8 result fits only if the bits above [22] are all sign copies
            if (!((&p[31:23]) || !(|p[31:23]))) begin
               ovf = 1'b1;
               y   = p[31] ? Q_MIN : Q_MAX;
            end else begin
               y = p[23:8];
            end
         end
         LOP_CMP: y = ($signed(a) > $signed(b)) ? Q_ONE : '0;
         LOP_SHF: y = b[4] ? LW'($signed(a) >>> b[3:0]) : (a << b[3:0]);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mpu_vec_alu.sv
// 4-lane Q8.8 packed-SIMD execution stage with valid/ready handshakes.
// Single-cycle ops resolve at acceptance; mul iterates one lane per cycle.
module mpu_vec_alu
   import mpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          add,
   input  logic          sub,
   input  logic          mul,
   input  logic          compare,
   input  logic          shift,
   input  logic          sfmx,
   input  logic          root,
   input  logic          exp,
   input  logic          S_en,
   input  logic          V_en,
   input  logic [4:0]    W_addr,
   input  logic [DW-1:0] data_out1,
   input  logic [DW-1:0] data_out2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic [4:0]    res_waddr,
   output logic          ovf,
   output logic          err
);

   state_t        state_q, state_d;
   logic [1:0]    cnt_q;
   logic [DW-1:0] a_q, b_q, result_q;
   logic          all_q, ovf_q, err_q;
   logic [4:0]    waddr_q;

   logic [7:0]    ops;
   logic          accept, legal;
   lane_op_t      sc_op;
   logic [DW-1:0] b_eff, sc_res;
   logic          sc_ovf;
   logic [LW-1:0] y_l [LANES];
   logic          ovf_l [LANES];
   logic [LW-1:0] qa_l [LANES];
   logic [LW-1:0] qb_l [LANES];
   logic [LW-1:0] mul_y, vmax;
   logic          mul_ovf, mul_en;

   assign ops    = {exp, root, sfmx, shift, compare, mul, sub, add};
   assign legal  = $onehot(ops) && !ops[OP_ROOT] && !ops[OP_EXP];
   assign accept = in_valid && in_ready;

   always_comb begin
      sc_op = LOP_ADD;
      if (ops[OP_SUB])      sc_op = LOP_SUB;
      else if (ops[OP_MUL]) sc_op = LOP_MUL;
      else if (ops[OP_CMP]) sc_op = LOP_CMP;
      else if (ops[OP_SHF]) sc_op = LOP_SHF;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign b_eff[i*LW +: LW] = S_en ? data_out2[LW-1:0] : data_out2[i*LW +: LW];
      assign qa_l[i] = a_q[i*LW +: LW];
      assign qb_l[i] = b_q[i*LW +: LW];
      mpu_q88_lane u_lane (
         .op  (sc_op),
         .a   (data_out1[i*LW +: LW]),
         .b   (b_eff[i*LW +: LW]),
         .y   (y_l[i]),
         .ovf (ovf_l[i])
      );
   end

   // Without S_en/V_en only lane 0 is live; the rest read as zero
   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (i == 0 || S_en || V_en) begin
            sc_res[i*LW +: LW] = y_l[i];
            sc_ovf             = sc_ovf | ovf_l[i];
         end
      end
   end

   assign vmax = smax(smax(data_out1[0*LW +: LW], data_out1[1*LW +: LW]),
                      smax(data_out1[2*LW +: LW], data_out1[3*LW +: LW]));

   mpu_q88_lane u_mul (
      .op  (LOP_MUL),
      .a   (qa_l[cnt_q]),
      .b   (qb_l[cnt_q]),
      .y   (mul_y),
      .ovf (mul_ovf)
   );

   assign mul_en = all_q || (cnt_q == 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = (legal && ops[OP_MUL]) ? ST_MUL : ST_DONE;
         ST_MUL:  if (cnt_q == 2'd3) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         all_q    <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         waddr_q  <= '0;
      end else if (accept) begin
         cnt_q   <= '0;
         a_q     <= data_out1;
         b_q     <= b_eff;
         all_q   <= S_en || V_en;
         waddr_q <= W_addr;
         err_q   <= !legal;
         if (!legal || ops[OP_MUL]) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
         end else if (ops[OP_SFMX]) begin
            result_q <= {LANES{vmax}};
            ovf_q    <= 1'b0;
         end else begin
            result_q <= sc_res;
            ovf_q    <= sc_ovf;
         end
      end else if (state_q == ST_MUL) begin
         cnt_q <= cnt_q + 2'd1;
         ovf_q <= ovf_q | (mul_en & mul_ovf);
         for (int unsigned i = 0; i < LANES; i++) begin
            if (cnt_q == 2'(i)) result_q[i*LW +: LW] <= mul_en ? mul_y : '0;
         end
      end
   end

   assign result    = result_q;
   assign res_waddr = waddr_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mpu_vec_alu.sv
// Directed self-checking bench for mpu_vec_alu: handshake timing, lane modes,
// saturation, iterative mul, backpressure, mid-mul reset and illegal bundles.
module tb_mpu_vec_alu;

   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic        add, sub, mul, compare, shift, sfmx, root, exp;
   logic        S_en, V_en;
   logic [4:0]  W_addr, res_waddr;
   logic [63:0] data_out1, data_out2, result;
   logic        ovf, err;

   int total = 0;
   int bad   = 0;

   mpu_vec_alu dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .add(add), .sub(sub), .mul(mul), .compare(compare), .shift(shift),
      .sfmx(sfmx), .root(root), .exp(exp), .S_en(S_en), .V_en(V_en),
      .W_addr(W_addr), .data_out1(data_out1), .data_out2(data_out2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .res_waddr(res_waddr), .ovf(ovf), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // ops order: {exp, root, sfmx, shift, compare, mul, sub, add}
   task automatic set_ops(input logic [7:0] o);
      {exp, root, sfmx, shift, compare, mul, sub, add} = o;
   endtask

   task automatic send(input logic [7:0] o, input logic s, input logic v,
                       input logic [4:0] wa, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      set_ops(o);
      S_en = s; V_en = v; W_addr = wa; data_out1 = a; data_out2 = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      set_ops(8'h00);
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic        seen;
      logic [63:0] held;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_ops(8'h00);
      S_en = 0; V_en = 0; W_addr = '0; data_out1 = '0; data_out2 = '0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_waddr", res_waddr, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // add, vector mode
      send(8'h01, 0, 1, 5'd7, 64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200);
      chk("add_valid", out_valid, 1);
      chk("add_in_ready", in_ready, 0);
      chk("add_result", result, 64'h0300_0300_0300_0300);
      chk("add_ovf", ovf, 0);
      chk("add_waddr", res_waddr, 5'd7);
      drain();
      chk("add_drop_valid", out_valid, 0);
      chk("add_ready_back", in_ready, 1);

      // add saturation, lane 0 only
      send(8'h01, 0, 0, 5'd3, 64'h1111_2222_3333_7F00, 64'h0001_0001_0001_0200);
      chk("sat_result", result, 64'h0000_0000_0000_7FFF);
      chk("sat_ovf", ovf, 1);
      chk("sat_err", err, 0);
      drain();

      // mul, scalar broadcast: 2.0 * -1.0
      send(8'h04, 1, 0, 5'd12, 64'h0200_0200_0200_0200, 64'h0000_0000_0000_FF00);
      chk("mul_valid_e0", out_valid, 0);
      chk("mul_ready_e0", in_ready, 0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         chk("mul_valid_early", out_valid, 0);
         chk("mul_ready_busy", in_ready, 0);
      end
      @(posedge clk);
      #1;
      chk("mul_valid_e4", out_valid, 1);
      chk("mul_result", result, 64'hFE00_FE00_FE00_FE00);
      chk("mul_ovf", ovf, 0);
      chk("mul_waddr", res_waddr, 5'd12);
      drain();

      // sfmx horizontal max
      send(8'h20, 0, 0, 5'd1, 64'h0005_FFFF_0100_0080, 64'hDEAD_BEEF_0000_1234);
      chk("sfmx_result", result, 64'h0100_0100_0100_0100);
      chk("sfmx_ovf", ovf, 0);
      drain();

      // shift: left by B[3:0], arithmetic right when B[4] set
      send(8'h10, 0, 1, 5'd2, 64'h8000_0100_0100_0003, 64'h0014_0001_0004_0001);
      chk("shift_result", result, 64'hF800_0200_1000_0006);
      drain();

      // compare with backpressure; a second bundle must be ignored
      send(8'h08, 0, 1, 5'd9, 64'h0200_0200_0200_0200, 64'h0100_0100_0100_0100);
      chk("cmp_result", result, 64'h0100_0100_0100_0100);
      held = result;
      @(negedge clk);
      set_ops(8'h01); V_en = 1; W_addr = 5'd30;
      data_out1 = 64'h1234_1234_1234_1234; data_out2 = 64'h1111_1111_1111_1111;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("bp_result_stable", result, 64'h0100_0100_0100_0100);
         chk("bp_waddr_stable", res_waddr, 5'd9);
         chk("bp_valid_held", out_valid, 1);
         chk("bp_in_ready_low", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      set_ops(8'h00);
      chk("bp_before_xfer", in_ready, 0);
      drain();
      chk("bp_ready_after", in_ready, 1);
      chk("bp_valid_after", out_valid, 0);
      @(posedge clk);
      #1;
      chk("bp_no_ghost", out_valid, 0);

      // reset pulsed during mul lane 2
      send(8'h04, 0, 1, 5'd21, 64'h0200_0200_0200_0200, 64'h0100_0100_0100_0100);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_in_ready", in_ready, 1);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_result", result, 0);
      chk("mrst_waddr", res_waddr, 0);
      chk("mrst_ovf", ovf, 0);
      chk("mrst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      chk("mrst_no_valid", seen, 0);

      // illegal bundle: add and sub together
      send(8'h03, 0, 1, 5'd4, 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100);
      chk("err_valid", out_valid, 1);
      chk("err_flag", err, 1);
      chk("err_result", result, 0);
      chk("err_ovf", ovf, 0);
      drain();

      // root alone is also illegal
      send(8'h40, 0, 1, 5'd6, 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100);
      chk("root_err", err, 1);
      chk("root_result", result, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
